// File: rtl/line_buffers_randomiser.sv
// Two cascaded single-line RAMs for the 3x3 window rows, plus an LFSR
// brightness noise source for the noise video mode.
module line_buffers_randomiser #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 2200,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] ram_pix1,
  output logic [DATA_WIDTH-1:0] ram_pix2,
  output logic [5:0]            brightness
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];
  localparam logic [15:0]         SEED    = 16'hACE1;

  logic [DATA_WIDTH-1:0] mem0 [DEPTH];
  logic [DATA_WIDTH-1:0] mem1 [DEPTH];
  logic [15:0]           lfsr;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  fb;

  assign wr_ok = wea && ({1'b0, addra} < DEPTH_L);
  assign rd_ok = {1'b0, addrb} < DEPTH_L;
  assign fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Memory is never cleared; reset only gates writes and the read registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_pix1 <= '0;
      ram_pix2 <= '0;
    end else begin
      if (wr_ok) begin
        mem0[addra] <= dina;
        mem1[addra] <= ram_pix1;
      end
      if (rd_ok) begin
        ram_pix1 <= mem0[addrb];
        ram_pix2 <= mem1[addrb];
      end else begin
        ram_pix1 <= '0;
        ram_pix2 <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[14:0], fb};
    end
  end

  assign brightness = lfsr[5:0];

endmodule

// File: tb/tb_line_buffers_randomiser.sv
// Directed self-checking bench for line_buffers_randomiser.
// Covers reset, latency, collision, cascade, range and mid-line reset.
module tb_line_buffers_randomiser;

  logic        clk;
  logic        rst;
  logic        wea;
  logic [11:0] addra;
  logic [23:0] dina;
  logic [11:0] addrb;
  logic [23:0] ram_pix1;
  logic [23:0] ram_pix2;
  logic [5:0]  brightness;

  int n_chk;
  int n_fail;

  line_buffers_randomiser #(
    .DATA_WIDTH(24),
    .DEPTH(2200),
    .ADDR_WIDTH(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wea(wea),
    .addra(addra),
    .dina(dina),
    .addrb(addrb),
    .ram_pix1(ram_pix1),
    .ram_pix2(ram_pix2),
    .brightness(brightness)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] exp_b [4];
    exp_b[0] = 6'd3;
    exp_b[1] = 6'd7;
    exp_b[2] = 6'd15;
    exp_b[3] = 6'd30;
    rst = 1'b1;
    wea = 1'b0;
    addra = '0;
    addrb = '0;
    dina = '0;
    step();
    step();
    n_chk++;
    if (brightness !== 6'd33 || ram_pix1 !== 24'h0 || ram_pix2 !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_state: b=%0d p1=%h p2=%h want b=33 p1=0 p2=0",
               brightness, ram_pix1, ram_pix2);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_chk++;
      if (brightness !== exp_b[i]) begin
        n_fail++;
        $display("FAIL lfsr_seq[%0d]: got %0d want %0d", i, brightness, exp_b[i]);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (brightness !== 6'd33) begin
      n_fail++;
      $display("FAIL async_reseed: got %0d want 33", brightness);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    wea = 1'b1;
    addra = 12'd10;
    dina = 24'h123456;
    addrb = 12'd0;
    step();
    wea = 1'b0;
    addrb = 12'd10;
    step();
    n_chk++;
    if (ram_pix1 !== 24'h123456) begin
      n_fail++;
      $display("FAIL write_read: got %h want 123456", ram_pix1);
    end
  endtask

  task automatic test_collision();
    wea = 1'b1;
    addra = 12'd5;
    dina = 24'hAAAAAA;
    addrb = 12'd0;
    step();
    addrb = 12'd5;
    dina = 24'h555555;
    step();
    n_chk++;
    if (ram_pix1 !== 24'hAAAAAA) begin
      n_fail++;
      $display("FAIL collision_old: got %h want aaaaaa", ram_pix1);
    end
    wea = 1'b0;
    step();
    n_chk++;
    if (ram_pix1 !== 24'h555555) begin
      n_fail++;
      $display("FAIL collision_new: got %h want 555555", ram_pix1);
    end
  endtask

  task automatic test_cascade();
    logic [23:0] e1;
    logic [23:0] e2;
    wea = 1'b1;
    for (int a = 0; a < 2200; a++) begin
      addra = 12'(a);
      addrb = 12'(a + 2);
      dina = 24'(a);
      step();
    end
    for (int a = 0; a < 2200; a++) begin
      addra = 12'(a);
      addrb = 12'(a + 2);
      dina = 24'h100000 | 24'(a);
      step();
      e1 = (a <= 2197) ? 24'(a + 2) : 24'h0;
      n_chk++;
      if (ram_pix1 !== e1) begin
        n_fail++;
        $display("FAIL cascade_l1_pix1[%0d]: got %h want %h", a, ram_pix1, e1);
      end
    end
    for (int a = 0; a < 2200; a++) begin
      addra = 12'(a);
      addrb = 12'(a + 2);
      dina = 24'h200000 | 24'(a);
      step();
      e1 = (a <= 2197) ? (24'h100000 | 24'(a + 2)) : 24'h0;
      e2 = (a <= 2196) ? 24'(a + 3) : 24'h0;
      n_chk++;
      if (ram_pix1 !== e1 || ram_pix2 !== e2) begin
        n_fail++;
        $display("FAIL cascade_l2[%0d]: p1=%h p2=%h want p1=%h p2=%h",
                 a, ram_pix1, ram_pix2, e1, e2);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [23:0] e1;
    logic [23:0] e2;
    wea = 1'b1;
    addra = 12'd2200;
    dina = 24'hFFFFFF;
    addrb = 12'd2200;
    step();
    n_chk++;
    if (ram_pix1 !== 24'h0 || ram_pix2 !== 24'h0) begin
      n_fail++;
      $display("FAIL oor_2200: p1=%h p2=%h want 0 0", ram_pix1, ram_pix2);
    end
    wea = 1'b0;
    addrb = 12'd2201;
    step();
    n_chk++;
    if (ram_pix1 !== 24'h0 || ram_pix2 !== 24'h0) begin
      n_fail++;
      $display("FAIL oor_2201: p1=%h p2=%h want 0 0", ram_pix1, ram_pix2);
    end
    for (int a = 0; a < 2200; a++) begin
      addrb = 12'(a);
      step();
      e1 = 24'h200000 | 24'(a);
      e2 = (a >= 1 && a <= 2198) ? (24'h100000 | 24'(a + 1)) : 24'h0;
      n_chk++;
      if (ram_pix1 !== e1 || ram_pix2 !== e2) begin
        n_fail++;
        $display("FAIL oor_intact[%0d]: p1=%h p2=%h want p1=%h p2=%h",
                 a, ram_pix1, ram_pix2, e1, e2);
      end
    end
  endtask

  task automatic test_reset_mid();
    wea = 1'b1;
    addrb = 12'd500;
    for (int a = 0; a < 100; a++) begin
      addra = 12'(a);
      dina = 24'h300000 | 24'(a);
      step();
    end
    n_chk++;
    if (ram_pix1 !== 24'h2001F4 || ram_pix2 !== 24'h1001F5) begin
      n_fail++;
      $display("FAIL mid_pre: p1=%h p2=%h want 2001f4 1001f5", ram_pix1, ram_pix2);
    end
    addra = 12'd100;
    dina = 24'hDEAD00;
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (ram_pix1 !== 24'h0 || ram_pix2 !== 24'h0 || brightness !== 6'd33) begin
      n_fail++;
      $display("FAIL mid_async: p1=%h p2=%h b=%0d want 0 0 33",
               ram_pix1, ram_pix2, brightness);
    end
    step();
    rst = 1'b0;
    wea = 1'b0;
    addrb = 12'd50;
    step();
    n_chk++;
    if (ram_pix1 !== 24'h300032 || brightness !== 6'd3) begin
      n_fail++;
      $display("FAIL mid_after50: p1=%h b=%0d want 300032 3", ram_pix1, brightness);
    end
    addrb = 12'd99;
    step();
    n_chk++;
    if (ram_pix1 !== 24'h300063) begin
      n_fail++;
      $display("FAIL mid_after99: got %h want 300063", ram_pix1);
    end
    addrb = 12'd100;
    step();
    n_chk++;
    if (ram_pix1 !== 24'h200064) begin
      n_fail++;
      $display("FAIL mid_blocked: got %h want 200064", ram_pix1);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_write_read();
    test_collision();
    test_cascade();
    test_out_of_range();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/line_buffers_randomiser.md
# line_buffers_randomiser

Video line-buffer and noise-source block for the pixel-processing pipeline. It holds two cascaded single-line RAMs: RAM0 stores the incoming line and RAM1 stores the line before it. Their read ports supply the middle and top rows of a 3x3 convolution window. A free-running LFSR produces a 6-bit pseudo-random brightness offset for the brightness-noise video mode.

## Interface
- `DATA_WIDTH`, 24: pixel width, packed {R,B,G} 8 bits each.
- `DEPTH`, 2200: words per line RAM, one per horizontal count including blanking.
- `ADDR_WIDTH`, 12: address width, must satisfy 2^ADDR_WIDTH ≥ DEPTH.
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `wea` in 1: write enable for both RAMs.
- `addra` in ADDR_WIDTH: write address (current hcount), shared by both RAMs.
- `dina` in DATA_WIDTH: write data for RAM0 (live video pixel).
- `addrb` in ADDR_WIDTH: read address, shared by both RAMs (hcount+2).
- `ram_pix1` out DATA_WIDTH: registered RAM0 read data (previous line).
- `ram_pix2` out DATA_WIDTH: registered RAM1 read data (line before previous).
- `brightness` out 6: pseudo-random offset, equal to lfsr[5:0].

## Operation
- **RAM0:** simple dual-port memory, DEPTH × DATA_WIDTH.
  - Write: if `wea` and addra < DEPTH, mem0[addra] ← dina.
  - Read: if addrb < DEPTH, ram_pix1 ← mem0[addrb]; otherwise ram_pix1 ← 0.
- **RAM1:** identical, except its write data is the current registered `ram_pix1`: mem1[addra] ← ram_pix1. Read output is `ram_pix2`. The cascade makes RAM1 one line older than RAM0.
- **Out-of-range write** (addra ≥ DEPTH): ignored, memory unchanged.
- **Read/write collision** (addra == addrb, same edge, wea=1): read-first. The read returns the old contents and the new data is visible on the next read.
- **Memory contents:** no initialisation and not cleared by reset. Contents are undefined until written; simulation models initialise them to 0.
- **LFSR:** 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Feedback fb = l[15]^l[13]^l[12]^l[10].
  - Each clock: l ← {l[14:0], fb}.
  - Free-running, no enable; never reaches all-zero from the seed.
- **Reset** (async, active-high), while rst=1:
  - ram_pix1 = 0, ram_pix2 = 0.
  - lfsr = 16'hACE1, so brightness = 6'd33.
  - RAM writes are blocked.
- **Reset release:** normal operation resumes on the first rising edge with rst=0.
- **Reset mid-line:** outputs clear immediately and writes in flight are dropped. Previously stored words remain readable after release.

## Timing
- **Read latency:** 1 cycle. ram_pix1 at edge t+1 = mem0[addrb sampled at edge t], read-first. ram_pix2 follows the same rule.
- **Write:** takes effect at the sampling edge; visible to a read issued on a later edge.
- **Line cascade:** a pixel written to RAM0 at address a appears on ram_pix1 when addrb=a on the next line. It is then written into RAM1 at whatever addra is current on that edge. With addrb = addra+2 as in the system, it lands at address a−1 relative to the read alignment; the window logic compensates.
- **brightness:** changes on every rising edge after reset release.
  - First edge after reset: 0x59C3 → brightness 3.
  - Second edge: 0xB387 → brightness 7.
- **Paths:** no combinational path from inputs to outputs.

## Test plan
- **Reset:** assert rst asynchronously mid-cycle → ram_pix1 = ram_pix2 = 0 and brightness = 33 immediately, before any clock edge. Release → brightness sequence 3, 7, … on successive edges.
- **Write/read latency:** with wea=1, write dina=24'h123456 at addra=10. Next cycle set addrb=10 → ram_pix1 = 24'h123456 exactly one edge later.
- **Collision:** mem0[5] = 24'hAAAAAA. On one edge drive addra=addrb=5, dina=24'h555555, wea=1 → ram_pix1 = 24'hAAAAAA. Read 5 again → 24'h555555.
- **Cascade:** write line 0 with pattern dina = address at addra 0..2199 (wea=1). Then stream line 1 with addrb = addra+2 → ram_pix1 shows line-0 values and RAM1 acquires them. On line 2, ram_pix2 returns line-0 data.
- **Out-of-range:** addrb = 2200 and 2201 → ram_pix1 = ram_pix2 = 0. A write with addra = 2200 leaves all of addresses 0..2199 unchanged.
- **Reset mid-operation:** pulse rst during a line write → outputs clear and brightness reseeds to 33. Words written before the pulse read back intact afterwards.
